// File: rtl/i2c_cmd_arbiter.sv
// Two-requester round-robin front end for a single I2C command controller.
// Handles the inter-command gap, NACK reissue, wait-phase timeouts and completion pulses.
module i2c_cmd_arbiter #(
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 65535,
  parameter int GAP_CYCLES = 2500
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iREQ0,
  input  logic [23:0] iDATA0,
  output logic        oDONE0,
  output logic        oERR0,
  input  logic        iREQ1,
  input  logic [23:0] iDATA1,
  output logic        oDONE1,
  output logic        oERR1,
  output logic        oI2C_GO,
  output logic [23:0] oI2C_DATA,
  input  logic        iI2C_END,
  input  logic        iI2C_ACK,
  output logic        oBUSY
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_END, RESP} state_t;

  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [2:0]  retry, retry_n;
  logic        g, g_n;
  logic        lp, lp_n;
  logic        err, err_n;
  logic        go, go_n;
  logic [23:0] data, data_n;

  function automatic logic [15:0] timer_inc(input logic [15:0] t);
    return (t == 16'hFFFF) ? t : t + 16'd1;
  endfunction

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      timer <= '0;
      retry <= '0;
      g     <= 1'b0;
      lp    <= 1'b1;
      err   <= 1'b0;
      go    <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      retry <= retry_n;
      g     <= g_n;
      lp    <= lp_n;
      err   <= err_n;
      go    <= go_n;
      data  <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    retry_n = retry;
    g_n     = g;
    lp_n    = lp;
    err_n   = err;
    go_n    = go;
    data_n  = data;
    case (state)
      IDLE: begin
        if (iREQ0 || iREQ1) begin
          // On contention the requester not served last wins
          g_n     = (iREQ0 && iREQ1) ? ~lp : iREQ1;
          data_n  = g_n ? iDATA1 : iDATA0;
          retry_n = '0;
          timer_n = '0;
          err_n   = 1'b0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        go_n = 1'b0;
        if (timer == GAP_LAST) begin
          go_n    = 1'b1;
          timer_n = '0;
          state_n = WAIT_BUSY;
        end else begin
          timer_n = timer_inc(timer);
        end
      end
      WAIT_BUSY: begin
        if (!iI2C_END) begin
          timer_n = '0;
          state_n = WAIT_END;
        end else if (timer == TO_LAST) begin
          go_n    = 1'b0;
          err_n   = 1'b1;
          state_n = RESP;
        end else begin
          timer_n = timer_inc(timer);
        end
      end
      WAIT_END: begin
        if (iI2C_END) begin
          go_n = 1'b0;
          if (!iI2C_ACK) begin
            err_n   = 1'b0;
            state_n = RESP;
          end else if (retry < RETRY_MAX) begin
            // Reissue the same word after another full gap
            retry_n = retry + 3'd1;
            timer_n = '0;
            state_n = ISSUE;
          end else begin
            err_n   = 1'b1;
            state_n = RESP;
          end
        end else if (timer == TO_LAST) begin
          go_n    = 1'b0;
          err_n   = 1'b1;
          state_n = RESP;
        end else begin
          timer_n = timer_inc(timer);
        end
      end
      RESP: begin
        lp_n    = g;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign oDONE0    = (state == RESP) && !g;
  assign oDONE1    = (state == RESP) && g;
  assign oERR0     = oDONE0 && err;
  assign oERR1     = oDONE1 && err;
  assign oI2C_GO   = go;
  assign oI2C_DATA = data;
  assign oBUSY     = (state != IDLE);

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a small behavioural I2C controller model.
module tb_i2c_cmd_arbiter;
  localparam int GAP = 4;
  localparam int TO  = 100;
  localparam int MR  = 3;

  logic        clk = 1'b0;
  logic        rst, req0, req1, done0, err0, done1, err1, go, i2c_end, i2c_ack, busy;
  logic [23:0] data0, data1, i2c_data;

  int total = 0;
  int bad   = 0;
  int nack_cfg = 0;
  bit stuck = 1'b0;

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.MAX_RETRY(MR), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .iCLK(clk), .iRST(rst),
    .iREQ0(req0), .iDATA0(data0), .oDONE0(done0), .oERR0(err0),
    .iREQ1(req1), .iDATA1(data1), .oDONE1(done1), .oERR1(err1),
    .oI2C_GO(go), .oI2C_DATA(i2c_data),
    .iI2C_END(i2c_end), .iI2C_ACK(i2c_ack), .oBUSY(busy)
  );

  // Controller model: goes busy 2 cycles after GO, ends 3 cycles later; NACKs the first nack_cfg attempts
  int phase = 0, cnt = 0, attempt = 0;
  always @(posedge clk) begin
    if (rst) begin
      i2c_end <= 1'b1;
      i2c_ack <= 1'b0;
      phase   <= 0;
      cnt     <= 0;
      attempt <= 0;
    end else begin
      if (!busy) attempt <= 0;
      case (phase)
        0: if (go && !stuck) begin phase <= 1; cnt <= 0; end
        1: if (!go) phase <= 0;
           else if (cnt == 1) begin i2c_end <= 1'b0; phase <= 2; cnt <= 0; end
           else cnt <= cnt + 1;
        2: if (cnt == 2) begin
             i2c_end <= 1'b1;
             i2c_ack <= (attempt < nack_cfg);
             attempt <= attempt + 1;
             phase   <= 3;
           end else cnt <= cnt + 1;
        default: if (!go) phase <= 0;
      endcase
    end
  end

  // Monitor: GO pulse statistics and DONE/ERR bookkeeping
  int rises = 0, short_gaps = 0, low_run = 0, high_run = 0, last_high = 0;
  int d0_cnt = 0, d1_cnt = 0, orphan = 0;
  bit go_prev = 1'b0;
  always @(negedge clk) begin
    if (go === 1'b1) begin
      if (!go_prev) begin
        rises++;
        if (low_run < GAP) short_gaps++;
        high_run = 0;
      end
      high_run++;
      go_prev = 1'b1;
    end else begin
      if (go_prev) begin last_high = high_run; low_run = 0; end
      low_run++;
      go_prev = 1'b0;
    end
    if (done0 === 1'b1) d0_cnt++;
    if (done1 === 1'b1) d1_cnt++;
    if ((err0 === 1'b1 && done0 !== 1'b1) || (err1 === 1'b1 && done1 !== 1'b1)) orphan++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_done(input string tag, output int who, output logic e);
    who = -1;
    e   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done0 || done1) begin
        who = done1 ? 1 : 0;
        e   = done1 ? err1 : err0;
        return;
      end
    end
    chk({tag, "_done_timeout"}, 0, 1);
  endtask

  int   who, b_r, b_s, b_d;
  logic e;
  bit   found;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    cyc(3);
    chk("rst_go", go, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done0, err0, done1, err1}, 0);
    rst = 1'b0;
    cyc(2);

    // single request
    b_r = rises; b_d = d1_cnt;
    data0 = 24'h340C00; req0 = 1'b1;
    cyc(1);
    chk("grant_busy", busy, 1);
    chk("grant_data", i2c_data, 24'h340C00);
    wait_done("single", who, e);
    req0 = 1'b0;
    chk("single_who", who, 0);
    chk("single_err", e, 0);
    chk("single_data", i2c_data, 24'h340C00);
    cyc(1);
    chk("single_one_pulse", done0, 0);
    cyc(3);
    chk("single_go_pulses", rises - b_r, 1);
    chk("single_no_done1", d1_cnt - b_d, 0);
    chk("single_idle", busy, 0);

    // contention from reset: order 0,1,0,1
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    data0 = 24'hA1A2A3; data1 = 24'hB1B2B3; req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done("rr", who, e);
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      chk($sformatf("rr_who%0d", k), who, k % 2);
      chk($sformatf("rr_data%0d", k), i2c_data, (k % 2) ? 24'hB1B2B3 : 24'hA1A2A3);
      chk($sformatf("rr_err%0d", k), e, 0);
    end
    cyc(3);
    chk("rr_idle", busy, 0);

    // two NACKs then ACK
    b_r = rises; b_s = short_gaps;
    nack_cfg = 2; data0 = 24'h123456; req0 = 1'b1;
    wait_done("nack", who, e);
    req0 = 1'b0;
    chk("nack_who", who, 0);
    chk("nack_err", e, 0);
    cyc(3);
    chk("nack_go_pulses", rises - b_r, 3);
    chk("nack_short_gaps", short_gaps - b_s, 0);

    // retries exhausted
    b_r = rises; b_s = short_gaps;
    nack_cfg = 99; req0 = 1'b1;
    wait_done("exh", who, e);
    req0 = 1'b0;
    chk("exh_who", who, 0);
    chk("exh_err", e, 1);
    cyc(3);
    chk("exh_go_pulses", rises - b_r, MR + 1);
    chk("exh_short_gaps", short_gaps - b_s, 0);
    chk("exh_err_clear", err0, 0);
    nack_cfg = 0;

    // END stuck high: timeout, no retry
    b_r = rises;
    stuck = 1'b1; data1 = 24'h0F0F0F; req1 = 1'b1;
    wait_done("to", who, e);
    req1 = 1'b0;
    chk("to_who", who, 1);
    chk("to_err", e, 1);
    cyc(3);
    chk("to_go_pulses", rises - b_r, 1);
    chk("to_go_high_cycles", last_high, TO);
    chk("to_err_clear", err1, 0);
    stuck = 1'b0;

    // reset during WAIT_END
    b_d = d0_cnt + d1_cnt;
    data0 = 24'h5A5A5A; req0 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc(1);
      if (busy && go && i2c_end === 1'b0) found = 1'b1;
    end
    chk("mr_reach_wait_end", found, 1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("mr_go", go, 0);
    chk("mr_data", i2c_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done_err", {done0, err0, done1, err1}, 0);
    rst = 1'b0; req0 = 1'b0;
    cyc(1);
    chk("mr_go_after", go, 0);
    cyc(10);
    chk("mr_no_done", d0_cnt + d1_cnt - b_d, 0);
    data0 = 24'h340C00; req0 = 1'b1;
    wait_done("mr_next", who, e);
    req0 = 1'b0;
    chk("mr_next_who", who, 0);
    chk("mr_next_err", e, 0);
    chk("mr_next_data", i2c_data, 24'h340C00);
    cyc(3);
    chk("err_only_with_done", orphan, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
